// File: rtl/axi4_burst_initiator.sv
// axi4_burst_initiator: directed AXI4 master that issues one INCR burst per command.
// Write bursts carry a seed-derived pattern; read bursts are checked for resp, ID and rlast placement.
// Optional feature macro: AXI_INIT_CHECK_EN adds the read-data comparator and the mismatch counter.
`timescale 1ns/1ps

`ifndef AXI_ADDR_WIDTH
`define AXI_ADDR_WIDTH 32
`endif
`ifndef AXI_DATA_WIDTH
`define AXI_DATA_WIDTH 64
`endif
`ifndef AXI_ID_WIDTH
`define AXI_ID_WIDTH 4
`endif

module axi4_burst_initiator #(
  parameter int ADDR_WIDTH = `AXI_ADDR_WIDTH,
  parameter int DATA_WIDTH = `AXI_DATA_WIDTH,
  parameter int ID_WIDTH   = `AXI_ID_WIDTH,
  parameter int TXN_ID     = 0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic                    cmd_write,
  input  logic [ADDR_WIDTH-1:0]   cmd_addr,
  input  logic [7:0]              cmd_len,
  input  logic [31:0]             cmd_seed,
  output logic                    done_valid,
  output logic                    done_error,
  output logic [15:0]             mismatch_cnt,
  output logic [ID_WIDTH-1:0]     m_axi_awid,
  output logic [ADDR_WIDTH-1:0]   m_axi_awaddr,
  output logic [7:0]              m_axi_awlen,
  output logic [2:0]              m_axi_awsize,
  output logic [1:0]              m_axi_awburst,
  output logic                    m_axi_awlock,
  output logic [3:0]              m_axi_awcache,
  output logic [2:0]              m_axi_awprot,
  output logic                    m_axi_awvalid,
  input  logic                    m_axi_awready,
  output logic [DATA_WIDTH-1:0]   m_axi_wdata,
  output logic [DATA_WIDTH/8-1:0] m_axi_wstrb,
  output logic                    m_axi_wlast,
  output logic                    m_axi_wvalid,
  input  logic                    m_axi_wready,
  input  logic [ID_WIDTH-1:0]     m_axi_bid,
  input  logic [1:0]              m_axi_bresp,
  input  logic                    m_axi_bvalid,
  output logic                    m_axi_bready,
  output logic [ID_WIDTH-1:0]     m_axi_arid,
  output logic [ADDR_WIDTH-1:0]   m_axi_araddr,
  output logic [7:0]              m_axi_arlen,
  output logic [2:0]              m_axi_arsize,
  output logic [1:0]              m_axi_arburst,
  output logic                    m_axi_arlock,
  output logic [3:0]              m_axi_arcache,
  output logic [2:0]              m_axi_arprot,
  output logic                    m_axi_arvalid,
  input  logic                    m_axi_arready,
  input  logic [ID_WIDTH-1:0]     m_axi_rid,
  input  logic [DATA_WIDTH-1:0]   m_axi_rdata,
  input  logic [1:0]              m_axi_rresp,
  input  logic                    m_axi_rlast,
  input  logic                    m_axi_rvalid,
  output logic                    m_axi_rready
);

  localparam int LANES = DATA_WIDTH / 32;
  localparam logic [2:0] AXSIZE = 3'($clog2(DATA_WIDTH / 8));
  localparam logic [ID_WIDTH-1:0] TXN_ID_V = ID_WIDTH'(TXN_ID);

  typedef enum logic [2:0] {IDLE, AW, W, B, AR, R, DONE} state_e;

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [7:0]              len_q, len_d;
  logic [31:0]             seed_q, seed_d;
  logic [8:0]              beat_q, beat_d;
  logic                    err_q, err_d;
  logic                    lastBeat;
  logic                    dataErr;

  // Beat i, lane k holds seed + i*LANES + k; lane 0 sits in the LSBs
  function automatic logic [DATA_WIDTH-1:0] patternBeat(input logic [31:0] seed, input logic [8:0] beat);
    logic [DATA_WIDTH-1:0] data;
    data = '0;
    for (int k = 0; k < LANES; k++) begin
      data[32*k +: 32] = seed + 32'(beat) * 32'(LANES) + 32'(k);
    end
    return data;
  endfunction

  assign lastBeat = (beat_q == {1'b0, len_q});

  assign cmd_ready     = (state_q == IDLE) && !rst;
  assign done_valid    = (state_q == DONE);
  assign done_error    = (state_q == DONE) && err_q;

  assign m_axi_awvalid = (state_q == AW);
  assign m_axi_awid    = m_axi_awvalid ? TXN_ID_V : '0;
  assign m_axi_awaddr  = addr_q;
  assign m_axi_awlen   = len_q;
  assign m_axi_awsize  = AXSIZE;
  assign m_axi_awburst = 2'b01;
  assign m_axi_awlock  = 1'b0;
  assign m_axi_awcache = 4'b0011;
  assign m_axi_awprot  = 3'b000;

  assign m_axi_wvalid  = (state_q == W);
  assign m_axi_wdata   = m_axi_wvalid ? patternBeat(seed_q, beat_q) : '0;
  assign m_axi_wstrb   = '1;
  assign m_axi_wlast   = m_axi_wvalid && lastBeat;
  assign m_axi_bready  = (state_q == B);

  assign m_axi_arvalid = (state_q == AR);
  assign m_axi_arid    = m_axi_arvalid ? TXN_ID_V : '0;
  assign m_axi_araddr  = addr_q;
  assign m_axi_arlen   = len_q;
  assign m_axi_arsize  = AXSIZE;
  assign m_axi_arburst = 2'b01;
  assign m_axi_arlock  = 1'b0;
  assign m_axi_arcache = 4'b0011;
  assign m_axi_arprot  = 3'b000;
  assign m_axi_rready  = (state_q == R);

`ifdef AXI_INIT_CHECK_EN
  logic [15:0] mismatchCnt_q, mismatchCnt_d;

  assign dataErr      = (m_axi_rdata != patternBeat(seed_q, beat_q));
  assign mismatch_cnt = mismatchCnt_q;

  // Count mismatching read beats across commands, holding at 0xFFFF
  always_comb begin
    mismatchCnt_d = mismatchCnt_q;
    if ((state_q == R) && m_axi_rvalid && dataErr && (mismatchCnt_q != 16'hFFFF)) begin
      mismatchCnt_d = mismatchCnt_q + 16'd1;
    end
  end

  // Mismatch counter register, cleared only by reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) mismatchCnt_q <= '0;
    else     mismatchCnt_q <= mismatchCnt_d;
  end
`else
  logic unusedRdata;

  assign unusedRdata  = ^m_axi_rdata;
  assign dataErr      = 1'b0;
  assign mismatch_cnt = '0;
`endif

  // Next-state and datapath update for the single outstanding burst
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    len_d   = len_q;
    seed_d  = seed_q;
    beat_d  = beat_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          addr_d  = cmd_addr;
          len_d   = cmd_len;
          seed_d  = cmd_seed;
          beat_d  = '0;
          err_d   = 1'b0;
          state_d = cmd_write ? AW : AR;
        end
      end
      AW: if (m_axi_awready) state_d = W;
      W: begin
        if (m_axi_wready) begin
          if (lastBeat) begin
            beat_d  = '0;
            state_d = B;
          end else begin
            beat_d = beat_q + 9'd1;
          end
        end
      end
      B: begin
        if (m_axi_bvalid) begin
          if ((m_axi_bresp != 2'b00) || (m_axi_bid != TXN_ID_V)) err_d = 1'b1;
          state_d = DONE;
        end
      end
      AR: if (m_axi_arready) state_d = R;
      R: begin
        if (m_axi_rvalid) begin
          if ((m_axi_rresp != 2'b00) || (m_axi_rid != TXN_ID_V) ||
              (m_axi_rlast != lastBeat) || dataErr) begin
            err_d = 1'b1;
          end
          if (m_axi_rlast || lastBeat) state_d = DONE;
          else                         beat_d  = beat_q + 9'd1;
        end
      end
      DONE: begin
        err_d   = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and command registers; reset abandons any burst in flight
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      len_q   <= '0;
      seed_q  <= '0;
      beat_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      len_q   <= len_d;
      seed_q  <= seed_d;
      beat_q  <= beat_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_axi4_burst_initiator.sv
// tb_axi4_burst_initiator: self-checking bench acting as the AXI slave for axi4_burst_initiator.
// Expected W beats and completion statuses go into queues when a command is driven.
`timescale 1ns/1ps

module tb_axi4_burst_initiator;

  localparam int AW_W = 32;
  localparam int DW   = 512;
  localparam int IW   = 4;
  localparam logic [3:0] TXN = 4'd5;

  logic            clk, rst;
  logic            cmd_valid, cmd_ready, cmd_write;
  logic [AW_W-1:0] cmd_addr;
  logic [7:0]      cmd_len;
  logic [31:0]     cmd_seed;
  logic            done_valid, done_error;
  logic [15:0]     mismatch_cnt;
  logic [IW-1:0]   m_axi_awid, m_axi_bid, m_axi_arid, m_axi_rid;
  logic [AW_W-1:0] m_axi_awaddr, m_axi_araddr;
  logic [7:0]      m_axi_awlen, m_axi_arlen;
  logic [2:0]      m_axi_awsize, m_axi_arsize, m_axi_awprot, m_axi_arprot;
  logic [1:0]      m_axi_awburst, m_axi_arburst, m_axi_bresp, m_axi_rresp;
  logic            m_axi_awlock, m_axi_arlock;
  logic [3:0]      m_axi_awcache, m_axi_arcache;
  logic            m_axi_awvalid, m_axi_awready, m_axi_arvalid, m_axi_arready;
  logic [DW-1:0]   m_axi_wdata, m_axi_rdata;
  logic [DW/8-1:0] m_axi_wstrb;
  logic            m_axi_wlast, m_axi_wvalid, m_axi_wready;
  logic            m_axi_bvalid, m_axi_bready;
  logic            m_axi_rlast, m_axi_rvalid, m_axi_rready;

  int            checks = 0;
  int            errors = 0;
  logic [511:0]  wQ[$];
  bit            doneQ[$];
  int            mmExp = 0;
  bit            checkEn;
  logic [511:0]  firstBeat, lastCap;

  axi4_burst_initiator #(
    .ADDR_WIDTH(AW_W), .DATA_WIDTH(DW), .ID_WIDTH(IW), .TXN_ID(5)
  ) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len), .cmd_seed(cmd_seed),
    .done_valid(done_valid), .done_error(done_error), .mismatch_cnt(mismatch_cnt),
    .m_axi_awid(m_axi_awid), .m_axi_awaddr(m_axi_awaddr), .m_axi_awlen(m_axi_awlen),
    .m_axi_awsize(m_axi_awsize), .m_axi_awburst(m_axi_awburst), .m_axi_awlock(m_axi_awlock),
    .m_axi_awcache(m_axi_awcache), .m_axi_awprot(m_axi_awprot), .m_axi_awvalid(m_axi_awvalid),
    .m_axi_awready(m_axi_awready),
    .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb), .m_axi_wlast(m_axi_wlast),
    .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
    .m_axi_bid(m_axi_bid), .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid),
    .m_axi_bready(m_axi_bready),
    .m_axi_arid(m_axi_arid), .m_axi_araddr(m_axi_araddr), .m_axi_arlen(m_axi_arlen),
    .m_axi_arsize(m_axi_arsize), .m_axi_arburst(m_axi_arburst), .m_axi_arlock(m_axi_arlock),
    .m_axi_arcache(m_axi_arcache), .m_axi_arprot(m_axi_arprot), .m_axi_arvalid(m_axi_arvalid),
    .m_axi_arready(m_axi_arready),
    .m_axi_rid(m_axi_rid), .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp),
    .m_axi_rlast(m_axi_rlast), .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready)
  );

  // Free-running 100 MHz clock
  always #5 clk = ~clk;

  // Abort a stuck run with a reported failure
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog got=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Reference pattern: 16 lanes, lane k of beat b = seed + 16*b + k
  function automatic logic [511:0] expPattern(input logic [31:0] seed, input int beat);
    logic [511:0] v;
    for (int lane = 0; lane < 16; lane++) begin
      v[lane*32 +: 32] = seed + 32'(beat * 16 + lane);
    end
    return v;
  endfunction

  // Count one comparison and report it when the DUT value differs
  task automatic checkOutput(input string tag, input logic [511:0] got, input logic [511:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Wait (bounded) for cmd_ready, then present one command for a single cycle
  task automatic applyStimulus(input bit wr, input logic [31:0] addr, input logic [7:0] len,
                               input logic [31:0] seed);
    int waitCyc;
    waitCyc = 0;
    while (!cmd_ready && waitCyc < 50) begin
      @(negedge clk);
      waitCyc++;
    end
    if (!cmd_ready) checkOutput("cmdReadyWait", cmd_ready, 1);
    cmd_valid = 1'b1;
    cmd_write = wr;
    cmd_addr  = addr;
    cmd_len   = len;
    cmd_seed  = seed;
    @(negedge clk);
    cmd_valid = 1'b0;
    checkOutput("cmdReadyBusy", cmd_ready, 0);
  endtask

  // Completion cycle, then the cycle after it must be back in IDLE
  task automatic checkDone();
    bit expErr;
    expErr = (doneQ.size() > 0) ? doneQ.pop_front() : 1'b0;
    checkOutput("doneValid", done_valid, 1);
    checkOutput("doneError", done_error, expErr);
    checkOutput("mismatchCnt", mismatch_cnt, mmExp);
    @(negedge clk);
    checkOutput("donePulse", done_valid, 0);
    checkOutput("cmdReadyBack", cmd_ready, 1);
  endtask

  task automatic runWrite(input logic [31:0] addr, input logic [7:0] len, input logic [31:0] seed,
                          input bit toggle, input int awWait, input logic [1:0] bresp,
                          input logic [3:0] bid);
    int hs, cyc;
    bit stalled;
    logic [511:0] held, e;
    for (int i = 0; i <= int'(len); i++) wQ.push_back(expPattern(seed, i));
    doneQ.push_back((bresp != 2'b00) || (bid != TXN));
    applyStimulus(1'b1, addr, len, seed);
    checkOutput("awvalid", m_axi_awvalid, 1);
    checkOutput("awaddr", m_axi_awaddr, addr);
    checkOutput("awlen", m_axi_awlen, len);
    checkOutput("awid", m_axi_awid, TXN);
    checkOutput("awsize", m_axi_awsize, 3'd6);
    checkOutput("awburst", m_axi_awburst, 2'b01);
    checkOutput("awcache", m_axi_awcache, 4'b0011);
    checkOutput("wBeforeAw", m_axi_wvalid, 0);
    for (int i = 0; i < awWait; i++) begin
      @(negedge clk);
      checkOutput("awHold", m_axi_awvalid, 1);
      checkOutput("awAddrStable", m_axi_awaddr, addr);
    end
    m_axi_awready = 1'b1;
    @(negedge clk);
    m_axi_awready = 1'b0;
    hs = 0;
    cyc = 0;
    stalled = 1'b0;
    while (hs <= int'(len) && cyc < 2000) begin
      m_axi_wready = toggle ? (cyc % 2 == 0) : 1'b1;
      if (stalled) checkOutput("wStable", m_axi_wdata, held);
      stalled = 1'b0;
      if (m_axi_wvalid && m_axi_wready) begin
        e = (wQ.size() > 0) ? wQ.pop_front() : '0;
        checkOutput("wdata", m_axi_wdata, e);
        checkOutput("wlast", m_axi_wlast, hs == int'(len));
        checkOutput("wstrb", m_axi_wstrb, {64{1'b1}});
        if (hs == 0) firstBeat = m_axi_wdata;
        lastCap = m_axi_wdata;
        hs++;
      end else if (m_axi_wvalid) begin
        stalled = 1'b1;
        held = m_axi_wdata;
      end
      cyc++;
      @(negedge clk);
    end
    if (hs <= int'(len)) checkOutput("wTimeout", 0, 1);
    m_axi_wready = 1'b0;
    checkOutput("wvalidAfterLast", m_axi_wvalid, 0);
    checkOutput("bready", m_axi_bready, 1);
    m_axi_bvalid = 1'b1;
    m_axi_bresp  = bresp;
    m_axi_bid    = bid;
    @(negedge clk);
    m_axi_bvalid = 1'b0;
    checkDone();
  endtask

  task automatic runRead(input logic [31:0] addr, input logic [7:0] len, input logic [31:0] cmdSeed,
                         input logic [31:0] dataSeed, input int rlastBeat, input logic [1:0] rresp,
                         input logic [3:0] rid);
    int sent;
    bit seedBad;
    seedBad = checkEn && (cmdSeed != dataSeed);
    doneQ.push_back((rresp != 2'b00) || (rid != TXN) || (rlastBeat != int'(len)) || seedBad);
    applyStimulus(1'b0, addr, len, cmdSeed);
    checkOutput("arvalid", m_axi_arvalid, 1);
    checkOutput("araddr", m_axi_araddr, addr);
    checkOutput("arlen", m_axi_arlen, len);
    checkOutput("arid", m_axi_arid, TXN);
    checkOutput("awvalidOnRead", m_axi_awvalid, 0);
    m_axi_arready = 1'b1;
    @(negedge clk);
    m_axi_arready = 1'b0;
    sent = 0;
    for (int b = 0; b <= int'(len); b++) begin
      checkOutput("rready", m_axi_rready, 1);
      m_axi_rvalid = 1'b1;
      m_axi_rdata  = expPattern(dataSeed, b);
      m_axi_rlast  = (b == rlastBeat);
      m_axi_rid    = rid;
      m_axi_rresp  = rresp;
      @(negedge clk);
      sent++;
      if (b == rlastBeat) break;
    end
    m_axi_rvalid = 1'b0;
    m_axi_rlast  = 1'b0;
    if (seedBad) mmExp += sent;
    checkDone();
  endtask

  initial begin
`ifdef AXI_INIT_CHECK_EN
    checkEn = 1'b1;
`else
    checkEn = 1'b0;
`endif
    clk = 1'b0; rst = 1'b1;
    cmd_valid = 0; cmd_write = 0; cmd_addr = '0; cmd_len = '0; cmd_seed = '0;
    m_axi_awready = 0; m_axi_wready = 0; m_axi_bvalid = 0; m_axi_bresp = '0; m_axi_bid = '0;
    m_axi_arready = 0; m_axi_rvalid = 0; m_axi_rdata = '0; m_axi_rresp = '0; m_axi_rlast = 0;
    m_axi_rid = '0;
    repeat (2) @(negedge clk);
    checkOutput("rstCmdReady", cmd_ready, 0);
    checkOutput("rstAwvalid", m_axi_awvalid, 0);
    checkOutput("rstWvalid", m_axi_wvalid, 0);
    checkOutput("rstArvalid", m_axi_arvalid, 0);
    checkOutput("rstBready", m_axi_bready, 0);
    checkOutput("rstRready", m_axi_rready, 0);
    checkOutput("rstDone", {done_valid, done_error}, 0);
    checkOutput("rstMismatch", mismatch_cnt, 0);
    checkOutput("rstPayload", {m_axi_awaddr, m_axi_awlen, m_axi_wdata}, 0);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("idleCmdReady", cmd_ready, 1);

    runWrite(32'h1000, 8'd3, 32'h10, 1'b0, 0, 2'b00, TXN);
    checkOutput("beat0Lane0", firstBeat[31:0], 32'h10);
    checkOutput("beat3Lane15", lastCap[511:480], 32'h4F);
    runRead(32'h1000, 8'd3, 32'h10, 32'h10, 3, 2'b00, TXN);
    runRead(32'h1000, 8'd3, 32'h11, 32'h10, 3, 2'b00, TXN);
    runWrite(32'h2000, 8'd7, 32'hABCD_0000, 1'b1, 2, 2'b00, TXN);
    runWrite(32'h2400, 8'd1, 32'h20, 1'b0, 0, 2'b10, TXN);
    runWrite(32'h2800, 8'd0, 32'h30, 1'b0, 0, 2'b00, 4'd2);
    runRead(32'h2000, 8'd3, 32'h40, 32'h40, 1, 2'b00, TXN);
    runRead(32'h2000, 8'd2, 32'h50, 32'h50, 300, 2'b00, TXN);
    runRead(32'h2000, 8'd1, 32'h60, 32'h60, 1, 2'b00, 4'd1);
    runRead(32'h2000, 8'd1, 32'h61, 32'h61, 1, 2'b11, TXN);
    runRead(32'h0000, 8'd255, 32'hFFFF_FF00, 32'hFFFF_FF00, 255, 2'b00, TXN);

    // Reset in the middle of a 16-beat write
    applyStimulus(1'b1, 32'h3000, 8'd15, 32'h5555_0000);
    checkOutput("awvalidMid", m_axi_awvalid, 1);
    m_axi_awready = 1'b1;
    @(negedge clk);
    m_axi_awready = 1'b0;
    m_axi_wready = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("inWState", m_axi_wvalid, 1);
    m_axi_wready = 1'b0;
    rst = 1'b1;
    #1;
    checkOutput("midRstAwvalid", m_axi_awvalid, 0);
    checkOutput("midRstWvalid", m_axi_wvalid, 0);
    checkOutput("midRstCmdReady", cmd_ready, 0);
    checkOutput("midRstWdata", m_axi_wdata, 0);
    repeat (3) begin
      @(negedge clk);
      checkOutput("midRstNoDone", done_valid, 0);
    end
    rst = 1'b0;
    mmExp = 0;
    checkOutput("midRstMismatch", mismatch_cnt, 0);
    @(negedge clk);
    runWrite(32'h3000, 8'd0, 32'h77, 1'b0, 0, 2'b00, TXN);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
